// File: rtl/regfile_writeback_queue_pkg.sv
// wb_pkg: shared types and constants for the register-file writeback queue.
//   wb_entry_t : one queued register write {addr, data} at default widths.
//   REG_ZERO   : hard-wired zero register; writes to it are dropped.
package wb_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_writeback_queue_fwd.sv
// wb_fwd_match: youngest-match search over the occupied queue entries.
//   head      : physical index of the oldest entry.
//   cnt       : number of occupied entries (age offsets 0..cnt-1 are valid).
//   ent_addr  : per-slot destination register, indexed by physical slot.
//   ent_data  : per-slot data.
//   lkp_addr  : register being read by decode.
//   hit/data  : youngest pending value for lkp_addr; 0 when no hit or lkp is r0.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic [PW-1:0]            head,
  input  logic [CW-1:0]            cnt,
  input  logic [DEPTH-1:0][AW-1:0] ent_addr,
  input  logic [DEPTH-1:0][DW-1:0] ent_data,
  input  logic [AW-1:0]            lkp_addr,
  output logic                     hit,
  output logic [DW-1:0]            data
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Walk in age order (offset from head) so wrapped entries rank correctly;
  // a later match overrides an earlier one, leaving the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    sum  = '0;
    idx  = '0;
    if (lkp_addr != AW'(REG_ZERO)) begin
      for (int i = 0; i < DEPTH; i++) begin
        sum = {1'b0, head} + (PW+1)'(i);
        if (sum >= (PW+1)'(DEPTH)) sum = sum - (PW+1)'(DEPTH);
        idx = sum[PW-1:0];
        if ((CW'(i) < cnt) && (ent_addr[idx] == lkp_addr)) begin
          hit  = 1'b1;
          data = ent_data[idx];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: buffers register writes from the load unit and the
// ALU and drains one per cycle into the register-file write port, in program
// order. Also forwards still-queued values to the rs/rt decode lookups.
//   clk, rst (async, active-low)
//   mem_valid/ready/addr/data : load-unit producer (older when both push)
//   alu_valid/ready/addr/data : ALU producer
//   wr_en/addr/data           : register-file write port, head of queue
//   rs_*, rt_*                : forwarding lookups (youngest queued match)
//   count/empty/full          : occupancy
module regfile_writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [AW-1:0]              mem_addr,
  input  logic [DW-1:0]              mem_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [AW-1:0]              alu_addr,
  input  logic [DW-1:0]              alu_data,
  output logic                       wr_en,
  output logic [AW-1:0]              wr_addr,
  output logic [DW-1:0]              wr_data,
  input  logic [AW-1:0]              rs_addr,
  output logic                       rs_hit,
  output logic [DW-1:0]              rs_data,
  input  logic [AW-1:0]              rt_addr,
  output logic                       rt_hit,
  output logic [DW-1:0]              rt_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH+1);
  localparam int N_LKP  = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          mem_push, alu_push, pop;
  logic [PW-1:0] mem_slot, alu_slot;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Ready looks only at the registered count. alu_ready keeps one extra slot
  // so a mem push and an alu push can both land in the same cycle.
  assign mem_ready = count_q < CW'(DEPTH);
  assign alu_ready = count_q < CW'(DEPTH-1);

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // r0 writes complete the handshake but are never stored.
  assign mem_push = mem_valid && mem_ready && (mem_addr != AW'(REG_ZERO));
  assign alu_push = alu_valid && alu_ready && (alu_addr != AW'(REG_ZERO));

  // The register file never stalls, so anything at head drains this cycle.
  assign pop = !empty;

  // mem is the older instruction, so it takes the first free slot.
  assign mem_slot = tail_q;
  assign alu_slot = mem_push ? ptr_inc(tail_q) : tail_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    tail_d = tail_q;
    if (mem_push) begin
      ent_d[mem_slot] = '{addr: mem_addr, data: mem_data};
      tail_d          = ptr_inc(tail_d);
    end
    if (alu_push) begin
      ent_d[alu_slot] = '{addr: alu_addr, data: alu_data};
      tail_d          = ptr_inc(tail_d);
    end
    head_d  = pop ? ptr_inc(head_q) : head_q;
    count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
  end

  // Write port: head entry straight from storage, forced to zero when empty.
  assign wr_en   = !empty;
  assign wr_addr = empty ? '0 : ent_q[head_q].addr;
  assign wr_data = empty ? '0 : ent_q[head_q].data;

  // Forwarding: search registered storage only; this cycle's pushes are
  // not visible until they are stored.
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [N_LKP-1:0][AW-1:0] lkp_addr;
  logic [N_LKP-1:0]         lkp_hit;
  logic [N_LKP-1:0][DW-1:0] lkp_data;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr[i] = ent_q[i].addr;
      ent_data[i] = ent_q[i].data;
    end
  end

  assign lkp_addr = {rt_addr, rs_addr};

  for (genvar g = 0; g < N_LKP; g++) begin : g_fwd
    wb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW),
      .PW    (PW),
      .CW    (CW)
    ) u_fwd (
      .head     (head_q),
      .cnt      (count_q),
      .ent_addr (ent_addr),
      .ent_data (ent_data),
      .lkp_addr (lkp_addr[g]),
      .hit      (lkp_hit[g]),
      .data     (lkp_data[g])
    );
  end

  assign rs_hit  = lkp_hit[0];
  assign rs_data = lkp_data[0];
  assign rt_hit  = lkp_hit[1];
  assign rt_data = lkp_data[1];

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    count_q <= CW'(DEPTH));
  a_no_empty_pop : assert property (@(posedge clk) disable iff (!rst)
    (count_q == '0) |-> !pop);

endmodule
